// File: rtl/core_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    OC_ILLEGAL,
    OC_LOAD,
    OC_OPIMM,
    OC_AUIPC,
    OC_STORE,
    OC_OP,
    OC_LUI,
    OC_BRANCH
  } opclass_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_A_RS1  = 2'b00;
  localparam logic [1:0] ALU_A_PC   = 2'b01;
  localparam logic [1:0] ALU_A_ZERO = 2'b10;

  localparam logic [1:0] HC_NONE    = 2'b00;
  localparam logic [1:0] HC_ILLEGAL = 2'b01;
  localparam logic [1:0] HC_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       pc_write;
    logic       ir_write;
    logic       branch;
    logic       memory_read;
    logic       memory_write;
    logic       memory_to_register;
    logic       alu_source;
    logic       register_write;
    logic [1:0] auipc_lui;
  } ctrl_t;

  function automatic logic uses_imm(opclass_t c);
    return c inside {OC_LOAD, OC_STORE, OC_OPIMM, OC_AUIPC, OC_LUI};
  endfunction

  function automatic logic [1:0] alu_a_sel(opclass_t c);
    case (c)
      OC_AUIPC: return ALU_A_PC;
      OC_LUI:   return ALU_A_ZERO;
      default:  return ALU_A_RS1;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction/data memory handshake between the sequencer and the memories.
interface multicycle_controller_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic memory_read;
  logic memory_write;

  modport master (
    output imem_req, dmem_req, memory_read, memory_write,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, memory_read, memory_write,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/opcode_classifier.sv
// Combinational RV32 major-opcode to instruction-class decode.
module opcode_classifier
  import core_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   opclass
);

  always_comb begin
    opclass = OC_ILLEGAL;
    case (opcode)
      OPC_LOAD:   opclass = OC_LOAD;
      OPC_OPIMM:  opclass = OC_OPIMM;
      OPC_AUIPC:  opclass = OC_AUIPC;
      OPC_STORE:  opclass = OC_STORE;
      OPC_OP:     opclass = OC_OP;
      OPC_LUI:    opclass = OC_LUI;
      OPC_BRANCH: opclass = OC_BRANCH;
      default:    opclass = OC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with memory
// wait-state timeout, illegal-opcode halt and cycle/retire counters.
module multicycle_controller
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [6:0]              opcode,
  multicycle_controller_if.master bus,
  output logic                    pc_write,
  output logic                    ir_write,
  output logic                    branch,
  output logic                    memory_to_register,
  output logic                    alu_source,
  output logic                    register_write,
  output logic [3:0]              alu_option,
  output logic [1:0]              AuipcLui,
  output logic                    halted,
  output logic [1:0]              halt_cause,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        instret_count
);

  // The MEM_TIMEOUT-th consecutive not-ready cycle is the last one allowed;
  // a ready in that same cycle still completes the access.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  opclass_t         cls_now, cls_q;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic             retire;
  ctrl_t            ctrl, ctrl_o;
  logic [CNT_W-1:0] cycle_q, instret_q;

  opcode_classifier u_cls (
    .opcode  (opcode),
    .opclass (cls_now)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= FETCH;
      cls_q     <= OC_ILLEGAL;
      wait_q    <= '0;
      cause_q   <= HC_NONE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (state_q == DECODE) cls_q <= cls_now;
      if (state_q != HALT) cycle_q <= cycle_q + 1'b1;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cause_d = cause_q;
    retire  = 1'b0;
    ctrl    = '0;
    case (state_q)
      FETCH: begin
        ctrl.imem_req = 1'b1;
        if (bus.imem_ready) begin
          ctrl.ir_write = 1'b1;
          state_d       = DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = HALT;
          cause_d = HC_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        if (cls_now == OC_ILLEGAL) begin
          state_d = HALT;
          cause_d = HC_ILLEGAL;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        ctrl.alu_source = uses_imm(cls_q);
        ctrl.auipc_lui  = alu_a_sel(cls_q);
        case (cls_q)
          OC_BRANCH: begin
            ctrl.branch   = 1'b1;
            ctrl.pc_write = 1'b1;
            retire        = 1'b1;
            state_d       = FETCH;
          end
          OC_LOAD, OC_STORE: state_d = MEMORY;
          default:           state_d = WRITEBACK;
        endcase
      end
      MEMORY: begin
        // alu_source stays high so the effective address is stable
        ctrl.dmem_req     = 1'b1;
        ctrl.alu_source   = 1'b1;
        ctrl.memory_read  = (cls_q == OC_LOAD);
        ctrl.memory_write = (cls_q == OC_STORE);
        if (bus.dmem_ready) begin
          if (cls_q == OC_STORE) begin
            ctrl.pc_write = 1'b1;
            retire        = 1'b1;
            state_d       = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = HALT;
          cause_d = HC_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WRITEBACK: begin
        ctrl.register_write     = 1'b1;
        ctrl.pc_write           = 1'b1;
        ctrl.memory_to_register = (cls_q == OC_LOAD);
        ctrl.alu_source         = uses_imm(cls_q);
        ctrl.auipc_lui          = alu_a_sel(cls_q);
        retire                  = 1'b1;
        state_d                 = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Strobes are forced low while reset is held so no access starts or completes.
  assign ctrl_o = RESET_N ? ctrl : '0;

  assign bus.imem_req       = ctrl_o.imem_req;
  assign bus.dmem_req       = ctrl_o.dmem_req;
  assign bus.memory_read    = ctrl_o.memory_read;
  assign bus.memory_write   = ctrl_o.memory_write;
  assign pc_write           = ctrl_o.pc_write;
  assign ir_write           = ctrl_o.ir_write;
  assign branch             = ctrl_o.branch;
  assign memory_to_register = ctrl_o.memory_to_register;
  assign alu_source         = ctrl_o.alu_source;
  assign register_write     = ctrl_o.register_write;
  assign AuipcLui           = ctrl_o.auipc_lui;

  assign alu_option    = {opcode[6:4], opcode[2]};
  assign halted        = (state_q == HALT);
  assign halt_cause    = cause_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven, hand-sequenced and random checks of multicycle_controller
// against a per-instruction strobe schedule built from the instruction rules.
module tb_multicycle_controller;
  import core_ctrl_pkg::*;

  localparam int TO    = 4;
  localparam int CNT_W = 32;

  localparam logic [11:0] B_IMEM = 12'h800, B_DMEM = 12'h400, B_PCW = 12'h200,
                          B_IRW  = 12'h100, B_BR   = 12'h080, B_RD  = 12'h040,
                          B_WR   = 12'h020, B_M2R  = 12'h010, B_SRC = 12'h008,
                          B_RW   = 12'h004;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic [6:0]       opcode = '0;
  logic             pc_write, ir_write, branch, memory_to_register, alu_source;
  logic             register_write, halted;
  logic [3:0]       alu_option;
  logic [1:0]       AuipcLui, halt_cause;
  logic [CNT_W-1:0] cycle_count, instret_count;

  logic             w_pc_write, w_ir_write, w_branch, w_m2r, w_alu_source;
  logic             w_register_write, w_halted;
  logic [3:0]       w_alu_option;
  logic [1:0]       w_AuipcLui, w_halt_cause;
  logic [2:0]       w_cycle_count, w_instret_count;

  multicycle_controller_if bus();
  multicycle_controller_if bus_w();
  assign bus_w.imem_ready = bus.imem_ready;
  assign bus_w.dmem_ready = bus.dmem_ready;

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .opcode(opcode), .bus(bus),
    .pc_write(pc_write), .ir_write(ir_write), .branch(branch),
    .memory_to_register(memory_to_register), .alu_source(alu_source),
    .register_write(register_write), .alu_option(alu_option),
    .AuipcLui(AuipcLui), .halted(halted), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  // Narrow-counter copy to observe silent wrap-around
  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut_w (
    .CLK(CLK), .RESET_N(RESET_N), .opcode(opcode), .bus(bus_w),
    .pc_write(w_pc_write), .ir_write(w_ir_write), .branch(w_branch),
    .memory_to_register(w_m2r), .alu_source(w_alu_source),
    .register_write(w_register_write), .alu_option(w_alu_option),
    .AuipcLui(w_AuipcLui), .halted(w_halted), .halt_cause(w_halt_cause),
    .cycle_count(w_cycle_count), .instret_count(w_instret_count)
  );

  always #5 CLK = ~CLK;

  logic [11:0] obs;
  assign obs = {bus.imem_req, bus.dmem_req, pc_write, ir_write, branch,
                bus.memory_read, bus.memory_write, memory_to_register,
                alu_source, register_write, AuipcLui};

  int          n_chk = 0, n_fail = 0;
  int          cyc_m = 0, ret_m = 0;
  logic [11:0] exp_q[$];
  logic [1:0]  exp_cause;
  int          exp_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic classify(input logic [6:0] op, output bit legal, output bit ld,
                          output bit st, output bit br, output logic [11:0] alu);
    legal = 1; ld = 0; st = 0; br = 0; alu = '0;
    case (op)
      7'b0000011: begin ld = 1; alu = B_SRC; end
      7'b0100011: begin st = 1; alu = B_SRC; end
      7'b0010011: alu = B_SRC;
      7'b0010111: alu = B_SRC | 12'd1;
      7'b0110111: alu = B_SRC | 12'd2;
      7'b0110011: alu = '0;
      7'b1100011: begin br = 1; alu = '0; end
      default:    legal = 0;
    endcase
  endtask

  // Expected strobe word for every non-halted cycle of one instruction
  task automatic build(input logic [6:0] op, input int fw, input int mw);
    bit legal, ld, st, br;
    logic [11:0] alu, m;
    exp_q.delete(); exp_cause = 2'd0; exp_ret = 0;
    classify(op, legal, ld, st, br, alu);
    for (int i = 0; i < fw && i < TO; i++) exp_q.push_back(B_IMEM);
    if (fw >= TO) begin exp_cause = 2'd2; return; end
    exp_q.push_back(B_IMEM | B_IRW);
    exp_q.push_back('0);
    if (!legal) begin exp_cause = 2'd1; return; end
    exp_q.push_back(br ? (alu | B_BR | B_PCW) : alu);
    if (br) begin exp_ret = 1; return; end
    if (ld || st) begin
      m = B_DMEM | B_SRC | (ld ? B_RD : B_WR);
      for (int i = 0; i < mw && i < TO; i++) exp_q.push_back(m);
      if (mw >= TO) begin exp_cause = 2'd2; return; end
      exp_q.push_back(st ? (m | B_PCW) : m);
      if (st) begin exp_ret = 1; return; end
    end
    exp_q.push_back(alu | B_RW | B_PCW | (ld ? B_M2R : 12'h0));
    exp_ret = 1;
  endtask

  // Entered just after a clock edge with the DUT in FETCH; memories answer
  // after fw / mw unanswered request cycles.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, output int lat);
    int fseen, mseen;
    logic [CNT_W-1:0] ret0;
    build(op, fw, mw);
    opcode = op; fseen = 0; mseen = 0; lat = 0;
    ret0 = instret_count;
    for (int n = 0; n < 40; n++) begin
      bus.imem_ready = bus.imem_req && (fseen >= fw);
      bus.dmem_ready = bus.dmem_req && (mseen >= mw);
      if (bus.imem_req) fseen++;
      if (bus.dmem_req) mseen++;
      @(negedge CLK);
      if (n < exp_q.size()) chk("strobes", 32'(obs), 32'(exp_q[n]));
      chk("alu_option", 32'(alu_option), 32'({op[6:4], op[2]}));
      @(posedge CLK); #1;
      lat = n + 1;
      if (halted || instret_count != ret0) break;
    end
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    cyc_m += exp_q.size();
    ret_m += exp_ret;
    chk("latency", lat, exp_q.size());
    chk("halt_cause", 32'(halt_cause), 32'(exp_cause));
    chk("halted", 32'(halted), 32'(exp_cause != 2'd0));
    chk("cycle_count", cycle_count, cyc_m);
    chk("instret_count", instret_count, ret_m);
    chk("wrap_cycle", 32'(w_cycle_count), cyc_m % 8);
    chk("wrap_instret", 32'(w_instret_count), ret_m % 8);
  endtask

  task automatic check_frozen(input int n);
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk("halt_strobes", 32'(obs), 0);
      chk("halt_flag", 32'(halted), 1);
      chk("halt_cycles", cycle_count, cyc_m);
      chk("halt_instret", instret_count, ret_m);
      @(posedge CLK); #1;
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0; opcode = '0;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_strobes", 32'(obs), 0);
      chk("rst_halt", 32'({halted, halt_cause}), 0);
      chk("rst_counts", cycle_count | instret_count, 0);
      chk("rst_alu_option", 32'(alu_option), 0);
      @(posedge CLK); #1;
    end
    RESET_N = 1'b1; bus.imem_ready = 1'b0;
    cyc_m = 0; ret_m = 0;
    #1;
    chk("rst_release_imem_req", 32'(bus.imem_req), 1);
  endtask

  typedef struct {
    logic [6:0] op;
    int         fw;
    int         mw;
    int         lat;
    int         ret;
    logic [1:0] cause;
  } vec_t;

  vec_t       vt[12];
  logic [6:0] legal_ops[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [CNT_W-1:0] r0;
    logic [6:0] op;
    int fw, mw;

    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    legal_ops = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011,
                  7'b0110011, 7'b0110111, 7'b1100011};
    vt[0]  = '{7'b0110011, 0,  0,  4,  1, 2'd0};
    vt[1]  = '{7'b0000011, 0,  3,  8,  1, 2'd0};
    vt[2]  = '{7'b0100011, 0,  0,  4,  1, 2'd0};
    vt[3]  = '{7'b0110111, 0,  0,  4,  1, 2'd0};
    vt[4]  = '{7'b1100011, 0,  0,  3,  1, 2'd0};
    vt[5]  = '{7'b0010111, 2,  0,  6,  1, 2'd0};
    vt[6]  = '{7'b0010011, 0,  0,  4,  1, 2'd0};
    vt[7]  = '{7'b0000011, 3,  3,  11, 1, 2'd0};
    vt[8]  = '{7'b0100011, 0,  2,  6,  1, 2'd0};
    vt[9]  = '{7'b1111111, 0,  0,  2,  0, 2'd1};
    vt[10] = '{7'b0110011, 99, 0,  4,  0, 2'd2};
    vt[11] = '{7'b0000011, 0,  99, 7,  0, 2'd2};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      r0 = instret_count;
      run_instr(vt[i].op, vt[i].fw, vt[i].mw, lat);
      chk("table_latency", lat, vt[i].lat);
      chk("table_retire", instret_count - r0, vt[i].ret);
      chk("table_cause", 32'(halt_cause), 32'(vt[i].cause));
      if (halted) begin
        check_frozen(10);
        do_reset();
      end
    end

    // Reset while a store is waiting in MEMORY: request drops, nothing retires
    do_reset();
    opcode = 7'b0100011; bus.imem_ready = 1'b1;
    @(posedge CLK); #1; bus.imem_ready = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mid_store_write", 32'(bus.memory_write), 1);
    @(posedge CLK); #1; RESET_N = 1'b0;
    @(negedge CLK);
    chk("mid_rst_drop", 32'(obs), 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mid_rst_idle", 32'(obs), 0);
    chk("mid_rst_no_retire", instret_count, 0);
    @(posedge CLK); #1;
    do_reset();

    for (int k = 0; k < 150; k++) begin
      op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 6)];
      fw = ($urandom_range(0, 24) == 0) ? TO : int'($urandom_range(0, TO - 1));
      mw = ($urandom_range(0, 24) == 0) ? TO : int'($urandom_range(0, TO - 1));
      run_instr(op, fw, mw, lat);
      if (halted) begin
        check_frozen(2);
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
